// File: rtl/raster_scan_if.sv
// Handshake and configuration bundle between the raster address generator and its host/consumer.
// The generator drives the coordinate stream (master); the host/consumer side is the slave.
interface raster_scan_if #(
    parameter int MAX_WIDTH  = 32,
    parameter int MAX_HEIGHT = 32,
    parameter int FCNT_W     = 8
);
    localparam int CW = (MAX_WIDTH  > 1) ? $clog2(MAX_WIDTH)  : 1;
    localparam int RW = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;

    logic              start;
    logic              stop;
    logic [CW:0]       cfg_width;
    logic [RW:0]       cfg_height;
    logic              cfg_continuous;
    logic              out_ready;
    logic              out_valid;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              first_col;
    logic              last_col;
    logic              first_row;
    logic              last_row;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;
    logic              busy;
    logic              cfg_err;

    modport master (
        input  start, stop, cfg_width, cfg_height, cfg_continuous, out_ready,
        output out_valid, col, row, first_col, last_col, first_row, last_row,
               frame_done, frame_cnt, busy, cfg_err
    );

    modport slave (
        output start, stop, cfg_width, cfg_height, cfg_continuous, out_ready,
        input  out_valid, col, row, first_col, last_col, first_row, last_row,
               frame_done, frame_cnt, busy, cfg_err
    );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Run-time sized 2-D raster (col x row) address generator that advances only on valid/ready beats,
// with single-shot or back-to-back frames, abort, and a wrapping completed-frame counter.
module raster_scan_ctrl #(
    parameter int MAX_WIDTH  = 32,
    parameter int MAX_HEIGHT = 32,
    parameter int FCNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    raster_scan_if.master sif
);
    localparam int CW = (MAX_WIDTH  > 1) ? $clog2(MAX_WIDTH)  : 1;
    localparam int RW = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     col, col_n;
    logic [RW-1:0]     row, row_n;
    logic [CW:0]       width_q, width_n;
    logic [RW:0]       height_q, height_n;
    logic              cont_q, cont_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic [FCNT_W-1:0] fcnt_q, fcnt_n;

    logic [CW:0]       width_m1;
    logic [RW:0]       height_m1;
    logic              at_last_col;
    logic              at_last_row;
    logic              cfg_legal;
    logic              beat;

    // Compare in the widened domain so a latched size of 0 (reset) never matches and MAX never overflows.
    assign width_m1    = width_q  - (CW+1)'(1);
    assign height_m1   = height_q - (RW+1)'(1);
    assign at_last_col = ({1'b0, col} == width_m1);
    assign at_last_row = ({1'b0, row} == height_m1);

    assign cfg_legal = (sif.cfg_width  != '0) && (sif.cfg_width  <= (CW+1)'(MAX_WIDTH)) &&
                       (sif.cfg_height != '0) && (sif.cfg_height <= (RW+1)'(MAX_HEIGHT));

    assign beat = (state == RUN) && sif.out_ready;

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        width_n  = width_q;
        height_n = height_q;
        cont_n   = cont_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        fcnt_n   = fcnt_q;
        case (state)
            IDLE: begin
                if (sif.start) begin
                    if (cfg_legal) begin
                        state_n  = RUN;
                        col_n    = '0;
                        row_n    = '0;
                        width_n  = sif.cfg_width;
                        height_n = sif.cfg_height;
                        cont_n   = sif.cfg_continuous;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    if (!at_last_col) begin
                        col_n = col + CW'(1);
                    end else if (!at_last_row) begin
                        col_n = '0;
                        row_n = row + RW'(1);
                    end else begin
                        col_n  = '0;
                        row_n  = '0;
                        done_n = 1'b1;
                        fcnt_n = fcnt_q + FCNT_W'(1);
                        if (!cont_q) begin
                            state_n = IDLE;
                        end
                    end
                end
                // Abort after any same-cycle beat has been accounted for above.
                if (sif.stop) begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            width_q  <= '0;
            height_q <= '0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            width_q  <= width_n;
            height_q <= height_n;
            cont_q   <= cont_n;
            done_q   <= done_n;
            err_q    <= err_n;
            fcnt_q   <= fcnt_n;
        end
    end

    assign sif.out_valid  = (state == RUN);
    assign sif.busy       = (state == RUN);
    assign sif.col        = col;
    assign sif.row        = row;
    assign sif.first_col  = (col == '0);
    assign sif.last_col   = at_last_col;
    assign sif.first_row  = (row == '0);
    assign sif.last_row   = at_last_row;
    assign sif.frame_done = done_q;
    assign sif.frame_cnt  = fcnt_q;
    assign sif.cfg_err    = err_q;
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: directed scenarios plus random traffic, checked every cycle against
// a pixel-index reference model (col = k mod w, row = k div w).
module tb_raster_scan_ctrl;
    localparam int MAXW = 32;
    localparam int MAXH = 32;
    localparam int FW   = 8;
    localparam int CW   = $clog2(MAXW);
    localparam int RW   = $clog2(MAXH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raster_scan_if #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH), .FCNT_W(FW)) sif ();

    raster_scan_ctrl #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH), .FCNT_W(FW)) u_dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: running flag, pixel index within frame, latched frame parameters.
    int m_run, m_k, m_w, m_h, m_cont, m_cnt, m_done, m_err;
    int cw, ch, cc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        int ec, er;
        ec = (m_run != 0) ? m_k % m_w : 0;
        er = (m_run != 0) ? m_k / m_w : 0;
        check("out_valid",  32'(sif.out_valid),  m_run);
        check("busy",       32'(sif.busy),       m_run);
        check("col",        32'(sif.col),        ec);
        check("row",        32'(sif.row),        er);
        check("frame_done", 32'(sif.frame_done), m_done);
        check("frame_cnt",  32'(sif.frame_cnt),  m_cnt);
        check("cfg_err",    32'(sif.cfg_err),    m_err);
        if (m_run != 0) begin
            check("first_col", 32'(sif.first_col), 32'(ec == 0));
            check("last_col",  32'(sif.last_col),  32'(ec == m_w - 1));
            check("first_row", 32'(sif.first_row), 32'(er == 0));
            check("last_row",  32'(sif.last_row),  32'(er == m_h - 1));
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit sp, input bit rd);
        m_done = 0;
        m_err  = 0;
        if (r) begin
            m_run = 0; m_k = 0; m_w = 0; m_h = 0; m_cont = 0; m_cnt = 0;
        end else if (m_run == 0) begin
            if (st) begin
                if (cw >= 1 && cw <= MAXW && ch >= 1 && ch <= MAXH) begin
                    m_run = 1; m_k = 0; m_w = cw; m_h = ch; m_cont = cc;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            if (rd) begin
                m_k++;
                if (m_k == m_w * m_h) begin
                    m_k    = 0;
                    m_done = 1;
                    m_cnt  = (m_cnt + 1) % (1 << FW);
                    if (m_cont == 0) m_run = 0;
                end
            end
            if (sp) begin
                m_run = 0;
                m_k   = 0;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model at the rising edge.
    task automatic cycle(input bit r, input bit st, input bit sp, input bit rd);
        compare_all();
        rst                = r;
        sif.start          = st;
        sif.stop           = sp;
        sif.out_ready      = rd;
        sif.cfg_width      = (CW+1)'(cw);
        sif.cfg_height     = (RW+1)'(ch);
        sif.cfg_continuous = cc[0];
        @(posedge clk);
        model_step(r, st, sp, rd);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int w, input int h, input int c);
        cw = w; ch = h; cc = c;
    endtask

    initial begin
        rst = 1'b1;
        sif.start = 1'b0; sif.stop = 1'b0; sif.out_ready = 1'b0;
        sif.cfg_width = '0; sif.cfg_height = '0; sif.cfg_continuous = 1'b0;
        set_cfg(0, 0, 0);
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0);

        // 4x3 single-shot, ready held high
        set_cfg(4, 3, 0);
        cycle(0, 1, 0, 1);
        repeat (14) cycle(0, 0, 0, 1);

        // 4x3 with ready toggling
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 28; i++) cycle(0, 0, 0, i[0]);

        // 2x2 continuous, three frames, then stop
        set_cfg(2, 2, 1);
        cycle(0, 1, 0, 1);
        repeat (12) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 1);

        // 1x1 single-shot
        set_cfg(1, 1, 0);
        cycle(0, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);

        // Largest frame
        set_cfg(MAXW, MAXH, 0);
        cycle(0, 1, 0, 1);
        repeat (MAXW * MAXH + 2) cycle(0, 0, 0, 1);

        // Illegal configurations
        set_cfg(0, 3, 0);
        cycle(0, 1, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        set_cfg(4, MAXH + 1, 0);
        cycle(0, 1, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        set_cfg(MAXW + 1, 2, 0);
        cycle(0, 1, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);

        // Stop at (2,1) of 4x3, then restart from (0,0)
        set_cfg(4, 3, 0);
        cycle(0, 1, 0, 1);
        repeat (6) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 1);
        repeat (4) cycle(0, 0, 0, 1);

        // Reset mid-frame, then restart
        cycle(1, 0, 0, 1);
        cycle(0, 1, 0, 1);
        repeat (5) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);

        // Frame counter wrap with back-to-back 1x1 frames
        set_cfg(1, 1, 1);
        cycle(0, 1, 0, 1);
        repeat ((1 << FW) + 4) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);

        // Random traffic; cfg changes freely mid-frame
        for (int i = 0; i < 3000; i++) begin
            set_cfg(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MAXW + 1)) : int'($urandom_range(1, 6)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MAXH + 1)) : int'($urandom_range(1, 5)),
                    int'($urandom_range(0, 1)));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
        end
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
